matmul_scheduler: RTL and testbench

//  Upstream sequencer for the MAC control FSM. Walks C[ROWS x COLS] = A[ROWS x K] * B[K x COLS]
//  one dot product at a time, in row-major order. For each output element it clears the

---
 rtl/matmul_scheduler.sv | 169 ++++++++++++++++
 tb/tb_matmul_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: walks C = A * B one dot product at a time in row-major
// order, driving the MAC control (start/cycles/done) and the result memory
// write port.
// Optional build macro: MATMUL_RELU_EN -- clamp negative results to zero.
module matmul_scheduler #(
   parameter  int SIZE   = 16,
   parameter  int DATA_W = 32,
   localparam int DIM_W  = $clog2(SIZE) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [DIM_W-1:0]     rows_in,
   input  logic [DIM_W-1:0]     cols_in,
   input  logic [DIM_W-1:0]     inner_in,
   output logic                 ctl_start,
   output logic [DIM_W-1:0]     ctl_cycles,
   input  logic                 ctl_done,
   input  logic [DATA_W-1:0]    acc_result,
   output logic                 acc_clr,
   output logic [DIM_W-1:0]     row_idx,
   output logic [DIM_W-1:0]     col_idx,
   output logic                 wr_en,
   output logic [2*DIM_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]    wr_data,
   output logic                 busy,
   output logic                 finished,
   output logic                 err
);

   localparam logic [DIM_W-1:0] LP_SIZE = DIM_W'(SIZE);
   localparam logic [DIM_W-1:0] LP_ONE  = DIM_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_ADVANCE,
      S_FIN
   } state_t;

   state_t              r_state;
   logic [DIM_W-1:0]    r_rows;
   logic [DIM_W-1:0]    r_cols;
   logic [DIM_W-1:0]    r_k;
   logic [DIM_W-1:0]    r_i;
   logic [DIM_W-1:0]    r_j;
   logic [DATA_W-1:0]   r_result;
   logic                r_ctl_start;
   logic                r_acc_clr;
   logic                r_wr_en;
   logic                r_busy;
   logic                r_finished;
   logic                r_err;

   logic                w_dims_ok;
   logic                w_last_col;
   logic                w_last_row;
   logic [DATA_W-1:0]   w_res_in;

   assign w_dims_ok  = (rows_in  != '0) && (rows_in  <= LP_SIZE) &&
                       (cols_in  != '0) && (cols_in  <= LP_SIZE) &&
                       (inner_in != '0) && (inner_in <= LP_SIZE);
   assign w_last_col = (r_j == r_cols - LP_ONE);
   assign w_last_row = (r_i == r_rows - LP_ONE);

`ifdef MATMUL_RELU_EN
   assign w_res_in = acc_result[DATA_W-1] ? '0 : acc_result;
`else
   assign w_res_in = acc_result;
`endif

   // Sequencer FSM; each strobe is set on the transition into the state it belongs to
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rows      <= '0;
         r_cols      <= '0;
         r_k         <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_result    <= '0;
         r_ctl_start <= 1'b0;
         r_acc_clr   <= 1'b0;
         r_wr_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_finished  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ctl_start <= 1'b0;
         r_acc_clr   <= 1'b0;
         r_wr_en     <= 1'b0;
         r_finished  <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  if (w_dims_ok) begin
                     r_rows    <= rows_in;
                     r_cols    <= cols_in;
                     r_k       <= inner_in;
                     r_i       <= '0;
                     r_j       <= '0;
                     r_busy    <= 1'b1;
                     r_acc_clr <= 1'b1;
                     r_state   <= S_CLEAR;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               r_ctl_start <= 1'b1;
               r_state     <= S_ISSUE;
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (ctl_done) begin
                  r_result <= w_res_in;
                  r_wr_en  <= 1'b1;
                  r_state  <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_state <= S_ADVANCE;
            end
            S_ADVANCE: begin
               if (w_last_col) begin
                  r_j <= '0;
                  r_i <= r_i + LP_ONE;
               end else begin
                  r_j <= r_j + LP_ONE;
               end
               if (w_last_col && w_last_row) begin
                  r_finished <= 1'b1;
                  r_state    <= S_FIN;
               end else begin
                  r_acc_clr <= 1'b1;
                  r_state   <= S_CLEAR;
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ctl_start  = r_ctl_start;
   assign ctl_cycles = r_k;
   assign acc_clr    = r_acc_clr;
   assign row_idx    = r_i;
   assign col_idx    = r_j;
   assign wr_en      = r_wr_en;
   assign wr_addr    = {r_i, r_j};
   assign wr_data    = r_result;
   assign busy       = r_busy;
   assign finished   = r_finished;
   assign err        = r_err;

endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: randomized self-checking bench for matmul_scheduler with
// a responding MAC-control model and an element-order reference model.
module tb_matmul_scheduler;

   localparam int SIZE   = 16;
   localparam int DATA_W = 32;
   localparam int DIM_W  = $clog2(SIZE) + 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 go;
   logic [DIM_W-1:0]     rows_in;
   logic [DIM_W-1:0]     cols_in;
   logic [DIM_W-1:0]     inner_in;
   logic                 ctl_start;
   logic [DIM_W-1:0]     ctl_cycles;
   logic                 ctl_done;
   logic [DATA_W-1:0]    acc_result;
   logic                 acc_clr;
   logic [DIM_W-1:0]     row_idx;
   logic [DIM_W-1:0]     col_idx;
   logic                 wr_en;
   logic [2*DIM_W-1:0]   wr_addr;
   logic [DATA_W-1:0]    wr_data;
   logic                 busy;
   logic                 finished;
   logic                 err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [DATA_W-1:0] forced_vals[$];

   always #5 clk = ~clk;

   matmul_scheduler #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .go         (go),
      .rows_in    (rows_in),
      .cols_in    (cols_in),
      .inner_in   (inner_in),
      .ctl_start  (ctl_start),
      .ctl_cycles (ctl_cycles),
      .ctl_done   (ctl_done),
      .acc_result (acc_result),
      .acc_clr    (acc_clr),
      .row_idx    (row_idx),
      .col_idx    (col_idx),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .finished   (finished),
      .err        (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Value the result memory should receive for a given accumulator output
   function automatic logic [DATA_W-1:0] model_store(input logic [DATA_W-1:0] v);
`ifdef MATMUL_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [DATA_W-1:0] next_val();
      if (forced_vals.size() > 0) return forced_vals.pop_front();
      return DATA_W'($urandom);
   endfunction

   task automatic check_all_zero(input string tag);
      check(tag, {ctl_start, ctl_cycles, acc_clr, row_idx, col_idx, wr_en,
                  wr_addr, wr_data, busy, finished, err}, '0);
   endtask

   task automatic bad_go(input int r, input int c, input int k);
      rows_in = DIM_W'(r); cols_in = DIM_W'(c); inner_in = DIM_W'(k);
      go = 1'b1;
      step();
      go = 1'b0;
      check("bad_err_pulse", err, 1);
      check("bad_busy", busy, 0);
      check("bad_no_start", {ctl_start, acc_clr}, 0);
      step();
      check("bad_err_end", err, 0);
      check("bad_busy2", busy, 0);
   endtask

   // Runs one full operation; abort_at > 0 resets the DUT while waiting on that start number
   task automatic run_op(input int r, input int c, input int k, input int abort_at,
                         input bit poke_busy);
      int cyc, starts, clrs, writes, done_cnt, last_done, budget, abort_cnt, n;
      bit fin_seen, aborted, poke_chk;
      logic [DIM_W-1:0] ei, ej;
      logic [DATA_W-1:0] v;
      logic [DATA_W-1:0] exp_q[$];
      cyc = 0; starts = 0; clrs = 0; writes = 0; done_cnt = -1; last_done = -1;
      abort_cnt = -1; fin_seen = 0; aborted = 0; poke_chk = 0;
      budget = r * c * (3 * k + 12) + 20;
      rows_in = DIM_W'(r); cols_in = DIM_W'(c); inner_in = DIM_W'(k);
      go = 1'b1;
      step();
      go = 1'b0;
      check("accept_busy", busy, 1);
      while (!fin_seen && !aborted && cyc < budget) begin
         if (poke_chk) begin
            check("busy_go_no_err", err, 0);
            go = 1'b0;
            poke_chk = 0;
         end
         if (ctl_start) begin
            starts++;
            n = starts - 1;
            ei = DIM_W'(n / c); ej = DIM_W'(n % c);
            check("start_cycles", ctl_cycles, k);
            check("start_idx", {row_idx, col_idx}, {ei, ej});
            if (last_done >= 0) check("done_to_start", cyc - last_done, 4);
            done_cnt = 3 * k + 1;
            if (abort_at == starts) abort_cnt = 2;
         end
         if (acc_clr) clrs++;
         if (wr_en) begin
            writes++;
            n = writes - 1;
            ei = DIM_W'(n / c); ej = DIM_W'(n % c);
            check("wr_vs_starts", writes, starts);
            check("wr_addr", wr_addr, {ei, ej});
            if (exp_q.size() > 0) check("wr_data", wr_data, exp_q.pop_front());
         end
         if (finished) begin
            fin_seen = 1;
            check("fin_writes", writes, r * c);
            check("fin_busy", busy, 1);
         end
         ctl_done = 1'b0;
         if (abort_cnt == 0) begin
            reset = 1'b1;
            step();
            check_all_zero("abort_zero");
            reset = 1'b0;
            ctl_done = 1'b1;
            acc_result = DATA_W'($urandom);
            step();
            ctl_done = 1'b0;
            for (int t = 0; t < 6; t++) begin
               check("abort_quiet", {wr_en, ctl_start, acc_clr, busy}, 0);
               step();
            end
            aborted = 1;
         end else begin
            if (done_cnt == 0) begin
               v = next_val();
               acc_result = v;
               ctl_done = 1'b1;
               exp_q.push_back(model_store(v));
               last_done = cyc;
            end else if (done_cnt == 3 * k + 1) begin
               ctl_done = 1'b1;
               acc_result = DATA_W'($urandom);
            end
            if (poke_busy && starts == 1 && done_cnt == 2) begin
               go = 1'b1;
               poke_chk = 1;
            end
            if (done_cnt >= 0) done_cnt--;
            if (abort_cnt > 0) abort_cnt--;
            step();
            cyc++;
         end
      end
      if (!aborted) begin
         check("fin_seen", fin_seen, 1);
         check("start_count", starts, r * c);
         check("clr_count", clrs, r * c);
         step();
         check("idle_busy", busy, 0);
         check("fin_one_pulse", finished, 0);
      end
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; ctl_done = 1'b0; acc_result = '0;
      rows_in = '0; cols_in = '0; inner_in = '0;
      repeat (2) step();
      check_all_zero("reset_zero");
      reset = 1'b0;
      step();

      forced_vals.push_back(32'hFFFF_FFF6);
      forced_vals.push_back(32'd7);
      run_op(2, 2, 2, 0, 1);

      bad_go(2, 2, 0);
      bad_go(SIZE + 1, 2, 2);
      bad_go(3, 0, 3);

      run_op(2, 2, 2, 2, 0);
      run_op(1, 1, 16, 0, 0);
      for (int t = 0; t < 4; t++)
         run_op(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 6)), 0, 0);
      run_op(SIZE, SIZE, SIZE, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
